// File: rtl/bus_sched_rr.sv
// Round-robin owner scheduler for the OR-wired system bus: one grant at a time, a dead
// turnaround cycle between owners, quantum preemption at idle bus, and a stuck-slave watchdog.
module bus_sched_rr #(
    parameter int NREQ    = 8,
    parameter int IDW     = 3,
    parameter int QUANTUM = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] bus_req,
    output logic [NREQ-1:0] bus_ack,
    input  logic            bus_rd,
    input  logic            bus_wr,
    input  logic            bus_ready,
    output logic [IDW-1:0]  owner,
    output logic            owner_valid,
    output logic            timeout_err,
    input  logic            clr_err
);
    localparam int BW = $clog2(QUANTUM + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  pick;
    logic [IDW-1:0]  nxt_ptr;
    logic [IDW:0]    cand;
    logic            pick_vld;
    logic [BW-1:0]   beats;
    logic [WW-1:0]   wdog;
    logic            busy;
    logic            wd_fire;
    logic            preempt;
    logic            release_bus;

    // Rotating-priority search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!pick_vld && bus_req[cand[IDW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[IDW-1:0];
            end
        end
    end

    // In GRANT bus_ack is onehot(owner), so masking it leaves only the waiters.
    always_comb begin
        busy        = bus_rd | bus_wr;
        wd_fire     = (wdog == WW'(TIMEOUT - 1)) && busy && !bus_ready;
        preempt     = (beats >= BW'(QUANTUM)) && (|(bus_req & ~bus_ack))
                      && !busy && !bus_ready;
        release_bus = wd_fire || !bus_req[owner] || preempt;
        nxt_ptr     = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus_ack     <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            timeout_err <= 1'b0;
            ptr         <= '0;
            beats       <= '0;
            wdog        <= '0;
        end else begin
            if (clr_err)
                timeout_err <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (pick_vld) begin
                        state       <= GRANT;
                        owner       <= pick;
                        bus_ack     <= ONE << pick;
                        owner_valid <= 1'b1;
                        beats       <= '0;
                        wdog        <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (bus_ready && beats < BW'(QUANTUM))
                        beats <= beats + BW'(1);
                    if (busy && !bus_ready)
                        wdog <= wdog + WW'(1);
                    else
                        wdog <= '0;
                    if (release_bus) begin
                        state       <= TURN;
                        bus_ack     <= '0;
                        owner_valid <= 1'b0;
                        ptr         <= nxt_ptr;
                        wdog        <= '0;
                    end
                    // Placed after the clear so a same-cycle set wins.
                    if (wd_fire)
                        timeout_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_sched_rr.sv
// Scoreboard bench for bus_sched_rr (QUANTUM=4, TIMEOUT=8): per-cycle expectations are queued
// as stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_bus_sched_rr;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_req = '0;
    logic       bus_rd = 1'b0, bus_wr = 1'b0, bus_ready = 1'b0, clr_err = 1'b0;
    logic [7:0] bus_ack;
    logic [2:0] owner;
    logic       owner_valid, timeout_err;

    typedef struct packed {
        logic [7:0] ack;
        logic [2:0] own;
        logic       ov;
        logic       te;
    } obs_t;

    typedef struct packed {
        logic [7:0] req;
        logic [3:0] ctl;   // {rd, wr, ready, clr_err}
        obs_t       exp;
    } row_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    bus_sched_rr #(.NREQ(8), .IDW(3), .QUANTUM(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_ack(bus_ack),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(bus_ready),
        .owner(owner), .owner_valid(owner_valid), .timeout_err(timeout_err),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        return {bus_ack, owner, owner_valid, timeout_err};
    endfunction

    function automatic row_t R(logic [7:0] req, logic [3:0] ctl, logic [7:0] ack,
                               logic [2:0] own, logic [1:0] ovte);
        row_t r;
        r.req = req;
        r.ctl = ctl;
        r.exp = {ack, own, ovte};
        return r;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        {bus_req, bus_rd, bus_wr, bus_ready, clr_err} = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        sb.push_back(obs_t'(0));
        @(negedge clk);
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL reset: got %h want %h", o, e);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        row_t rows[$];
        obs_t e, o;
        rows.push_back(R(8'h01, 4'h0, 8'h01, 3'd0, 2'b10));
        rows.push_back(R(8'h01, 4'h0, 8'h01, 3'd0, 2'b10));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd0, 2'b00));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd0, 2'b00));
        foreach (rows[i]) begin
            {bus_req, bus_rd, bus_wr, bus_ready, clr_err} = {rows[i].req, rows[i].ctl};
            sb.push_back(rows[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL single_grant[%0d]: got ack=%h own=%0d ov=%b err=%b want ack=%h own=%0d ov=%b err=%b",
                         i, o.ack, o.own, o.ov, o.te, e.ack, e.own, e.ov, e.te);
            end
        end
    endtask

    task automatic test_handoff();
        row_t rows[$];
        obs_t e, o;
        pulse_reset();
        rows.push_back(R(8'h03, 4'h0, 8'h01, 3'd0, 2'b10));
        rows.push_back(R(8'h02, 4'h0, 8'h00, 3'd0, 2'b00));
        rows.push_back(R(8'h02, 4'h0, 8'h02, 3'd1, 2'b10));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd1, 2'b00));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd1, 2'b00));
        foreach (rows[i]) begin
            {bus_req, bus_rd, bus_wr, bus_ready, clr_err} = {rows[i].req, rows[i].ctl};
            sb.push_back(rows[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL handoff[%0d]: got ack=%h own=%0d ov=%b err=%b want ack=%h own=%0d ov=%b err=%b",
                         i, o.ack, o.own, o.ov, o.te, e.ack, e.own, e.ov, e.te);
            end
        end
    endtask

    task automatic test_quantum_preempt();
        row_t rows[$];
        obs_t e, o;
        pulse_reset();
        rows.push_back(R(8'h03, 4'h0, 8'h01, 3'd0, 2'b10));
        repeat (4) rows.push_back(R(8'h03, 4'b0010, 8'h01, 3'd0, 2'b10));
        rows.push_back(R(8'h03, 4'b1000, 8'h01, 3'd0, 2'b10));  // bus busy: no preempt
        rows.push_back(R(8'h03, 4'h0, 8'h00, 3'd0, 2'b00));
        rows.push_back(R(8'h03, 4'h0, 8'h02, 3'd1, 2'b10));
        rows.push_back(R(8'h01, 4'h0, 8'h00, 3'd1, 2'b00));
        rows.push_back(R(8'h01, 4'h0, 8'h01, 3'd0, 2'b10));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd0, 2'b00));
        foreach (rows[i]) begin
            {bus_req, bus_rd, bus_wr, bus_ready, clr_err} = {rows[i].req, rows[i].ctl};
            sb.push_back(rows[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL quantum_preempt[%0d]: got ack=%h own=%0d ov=%b err=%b want ack=%h own=%0d ov=%b err=%b",
                         i, o.ack, o.own, o.ov, o.te, e.ack, e.own, e.ov, e.te);
            end
        end
    endtask

    task automatic test_quantum_alone();
        row_t rows[$];
        obs_t e, o;
        pulse_reset();
        rows.push_back(R(8'h01, 4'h0, 8'h01, 3'd0, 2'b10));
        repeat (10) rows.push_back(R(8'h01, 4'b0010, 8'h01, 3'd0, 2'b10));
        repeat (2) rows.push_back(R(8'h01, 4'h0, 8'h01, 3'd0, 2'b10));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd0, 2'b00));
        foreach (rows[i]) begin
            {bus_req, bus_rd, bus_wr, bus_ready, clr_err} = {rows[i].req, rows[i].ctl};
            sb.push_back(rows[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL quantum_alone[%0d]: got ack=%h own=%0d ov=%b err=%b want ack=%h own=%0d ov=%b err=%b",
                         i, o.ack, o.own, o.ov, o.te, e.ack, e.own, e.ov, e.te);
            end
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        obs_t e, o;
        pulse_reset();
        rows.push_back(R(8'h03, 4'h0, 8'h01, 3'd0, 2'b10));
        repeat (7) rows.push_back(R(8'h03, 4'b1000, 8'h01, 3'd0, 2'b10));
        rows.push_back(R(8'h03, 4'b1000, 8'h00, 3'd0, 2'b01));  // 8th stalled cycle revokes
        rows.push_back(R(8'h03, 4'h0, 8'h02, 3'd1, 2'b11));
        rows.push_back(R(8'h02, 4'b0001, 8'h02, 3'd1, 2'b10));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd1, 2'b00));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd1, 2'b00));
        foreach (rows[i]) begin
            {bus_req, bus_rd, bus_wr, bus_ready, clr_err} = {rows[i].req, rows[i].ctl};
            sb.push_back(rows[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL timeout[%0d]: got ack=%h own=%0d ov=%b err=%b want ack=%h own=%0d ov=%b err=%b",
                         i, o.ack, o.own, o.ov, o.te, e.ack, e.own, e.ov, e.te);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        obs_t e, o;
        pulse_reset();
        rows.push_back(R(8'h02, 4'h0, 8'h02, 3'd1, 2'b10));
        rows.push_back(R(8'h00, 4'h0, 8'h00, 3'd1, 2'b00));  // ptr moves to 2
        rows.push_back(R(8'h02, 4'h0, 8'h02, 3'd1, 2'b10));
        rows.push_back(R(8'h02, 4'h0, 8'h02, 3'd1, 2'b10));
        foreach (rows[i]) begin
            {bus_req, bus_rd, bus_wr, bus_ready, clr_err} = {rows[i].req, rows[i].ctl};
            sb.push_back(rows[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = observe(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got ack=%h own=%0d ov=%b err=%b want ack=%h own=%0d ov=%b err=%b",
                         i, o.ack, o.own, o.ov, o.te, e.ack, e.own, e.ov, e.te);
            end
        end
        rst = 1'b1;
        sb.push_back(obs_t'(0));
        #1;
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL reset_mid_async: got %h want %h", o, e);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_req = 8'h06;
        sb.push_back({8'h02, 3'd1, 2'b10});  // ptr back at 0 picks master 1, not 2
        @(negedge clk);
        e = sb.pop_front(); o = observe(); n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL reset_mid_rearb: got %h want %h", o, e);
        end
        bus_req = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_handoff();
        test_quantum_preempt();
        test_quantum_alone();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
